// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM.
package dp_ram_pkg;

    typedef enum int {
        RDW_NO_CHANGE   = 0,
        RDW_READ_FIRST  = 1,
        RDW_WRITE_FIRST = 2
    } rdw_mode_e;

    localparam int COLL_CNT_W = 8;

    // One byte lane: take the new byte when its enable is set.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/dp_ram_if.sv
// One RAM port: request and write signals from the master, read data and its strobe back.
interface dp_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    // en is a single-cycle request with no back-pressure (the RAM is always ready);
    // rvalid is a one-cycle strobe that qualifies rdata, which holds between strobes.
    logic                  en;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;

    modport master (output en, we, be, addr, wdata, input rdata, rvalid);
    modport slave  (input en, we, be, addr, wdata, output rdata, rvalid);

endinterface

// File: rtl/dp_ram_port_out.sv
// Per-port read path: read-during-write select, rvalid generation and optional output register.
module dp_ram_port_out
    import dp_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W-1:0]   old_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rvalid_o
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] s1_data_d, s1_data_q;
    logic              s1_vld_d, s1_vld_q;

    for (genvar i = 0; i < NB; i++) begin : g_merge
        assign merged[8*i +: 8] = byte_merge(old_i[8*i +: 8], wdata_i[8*i +: 8], be_i[i]);
    end

    assign wr_word = (RDW_MODE == RDW_WRITE_FIRST) ? merged : old_i;

    // old_i is the array word before this edge's writes, so plain reads and
    // cross-port reads both see the pre-write word.
    always_comb begin
        s1_vld_d  = 1'b0;
        s1_data_d = s1_data_q;
        if (en_i && !we_i) begin
            s1_vld_d  = 1'b1;
            s1_data_d = old_i;
        end else if (en_i && we_i && (RDW_MODE != RDW_NO_CHANGE)) begin
            s1_vld_d  = 1'b1;
            s1_data_d = wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] s2_data_q;
        logic              s2_vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_vld_q  <= 1'b0;
                s2_data_q <= '0;
            end else begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) s2_data_q <= s1_data_q;
            end
        end

        assign rdata_o  = s2_data_q;
        assign rvalid_o = s2_vld_q;
    end else begin : g_noreg
        assign rdata_o  = s1_data_q;
        assign rvalid_o = s1_vld_q;
    end

endmodule

// File: rtl/dp_ram_param.sv
// True dual-port synchronous RAM with byte enables, selectable read-during-write
// behaviour, optional output register and write-write collision arbitration.
module dp_ram_param
    import dp_ram_pkg::*;
#(
    parameter int DATA_W   = 8,   // multiple of 8
    parameter int ADDR_W   = 4,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0,
    parameter int PRIO_A   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dp_ram_if.slave               a,
    dp_ram_if.slave               b,
    output logic                  coll,
    output logic [COLL_CNT_W-1:0] coll_cnt
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic                  a_wr, b_wr;
    logic                  coll_d, coll_q;
    logic [NB-1:0]         a_be_eff, b_be_eff;
    logic [DATA_W-1:0]     a_old, b_old;
    logic [COLL_CNT_W-1:0] coll_cnt_d, coll_cnt_q;

    assign a_wr   = a.en & a.we;
    assign b_wr   = b.en & b.we;
    assign coll_d = a_wr & b_wr & (a.addr == b.addr);

    // On a collision the losing port drops only the bytes the winner also writes.
    always_comb begin
        a_be_eff = a.be;
        b_be_eff = b.be;
        if (coll_d) begin
            if (PRIO_A != 0) b_be_eff = b.be & ~a.be;
            else             a_be_eff = a.be & ~b.be;
        end
    end

    // One array per byte lane; the effective enables never overlap on a shared address.
    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic [7:0] lane_q [DEPTH];

        always_ff @(posedge clk) begin
            if (a_wr && a_be_eff[i]) lane_q[a.addr] <= a.wdata[8*i +: 8];
            if (b_wr && b_be_eff[i]) lane_q[b.addr] <= b.wdata[8*i +: 8];
        end

        assign a_old[8*i +: 8] = lane_q[a.addr];
        assign b_old[8*i +: 8] = lane_q[b.addr];
    end

    assign coll_cnt_d = (coll_d && (coll_cnt_q != '1)) ? coll_cnt_q + 1'b1 : coll_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            coll_q     <= coll_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    assign coll     = coll_q;
    assign coll_cnt = coll_cnt_q;

    dp_ram_port_out #(
        .DATA_W  (DATA_W),
        .RDW_MODE(RDW_MODE),
        .OUT_REG (OUT_REG)
    ) u_out_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (a.en),
        .we_i    (a.we),
        .be_i    (a.be),
        .wdata_i (a.wdata),
        .old_i   (a_old),
        .rdata_o (a.rdata),
        .rvalid_o(a.rvalid)
    );

    dp_ram_port_out #(
        .DATA_W  (DATA_W),
        .RDW_MODE(RDW_MODE),
        .OUT_REG (OUT_REG)
    ) u_out_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (b.en),
        .we_i    (b.we),
        .be_i    (b.be),
        .wdata_i (b.wdata),
        .old_i   (b_old),
        .rdata_o (b.rdata),
        .rvalid_o(b.rvalid)
    );

endmodule

// File: tb/tb_dp_ram_param.sv
// Bench for dp_ram_param: three configurations driven with identical stimulus and
// checked against a reference model through per-port expected-read queues.
module tb_dp_ram_param;
    import dp_ram_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NB = DW / 8;
    localparam int NI = 3;
    localparam int NP = 2 * NI;

    typedef struct packed {
        logic          dc;
        logic [31:0]   due;
        logic [DW-1:0] d;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // ---------------- DUTs ----------------
    logic          a_en, a_we, b_en, b_we;
    logic [NB-1:0] a_be, b_be;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wd, b_wd;

    logic                  rv     [NP];
    logic [DW-1:0]         rd     [NP];
    logic                  coll_o [NI];
    logic [COLL_CNT_W-1:0] cnt_o  [NI];

    // Instance g: RDW_MODE = g; instance 1 also has OUT_REG=1 and port B priority.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        dp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) a_if ();
        dp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) b_if ();

        assign a_if.en = a_en;  assign a_if.we = a_we;  assign a_if.be = a_be;
        assign a_if.addr = a_addr;  assign a_if.wdata = a_wd;
        assign b_if.en = b_en;  assign b_if.we = b_we;  assign b_if.be = b_be;
        assign b_if.addr = b_addr;  assign b_if.wdata = b_wd;

        dp_ram_param #(
            .DATA_W  (DW),
            .ADDR_W  (AW),
            .RDW_MODE(g),
            .OUT_REG ((g == 1) ? 1 : 0),
            .PRIO_A  ((g == 1) ? 0 : 1)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .a       (a_if),
            .b       (b_if),
            .coll    (coll_o[g]),
            .coll_cnt(cnt_o[g])
        );

        assign rv[2*g]   = a_if.rvalid;
        assign rd[2*g]   = a_if.rdata;
        assign rv[2*g+1] = b_if.rvalid;
        assign rd[2*g+1] = b_if.rdata;
    end

    function automatic int oreg_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic bit prio_a_of(input int i);
        return i != 1;
    endfunction

    // ---------------- model and scoreboard ----------------
    logic [DW-1:0]         mdl      [NI][16];
    bit                    known    [16];
    logic [COLL_CNT_W-1:0] cnt_m    [NI];
    logic                  exp_coll [NI];
    exp_t                  exp_q    [NP][$];
    logic [DW-1:0]         last_q   [NP];
    bit                    last_dc  [NP];
    int                    n_cmp = 0;
    int                    n_bad = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [NB-1:0] be);
        merge = o;
        for (int i = 0; i < NB; i++) if (be[i]) merge[8*i +: 8] = n[8*i +: 8];
    endfunction

    task automatic push(input int k, input logic [DW-1:0] d, input bit dc);
        exp_t e;
        e.dc  = dc;
        e.due = 32'(cyc_n + 1 + oreg_of(k / 2));
        e.d   = d;
        exp_q[k].push_back(e);
    endtask

    task automatic port_exp(input int i, input int k, input logic en, input logic we,
                            input logic [NB-1:0] be, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        if (!en) return;
        if (!we)                         push(k, mdl[i][ad], !known[ad]);
        else if (i == RDW_READ_FIRST)    push(k, mdl[i][ad], !known[ad]);
        else if (i == RDW_WRITE_FIRST)   push(k, merge(mdl[i][ad], wd, be), !known[ad] && (be != '1));
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic ae, input logic awe, input logic [NB-1:0] abe,
                       input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                       input logic bee, input logic bwe, input logic [NB-1:0] bbe,
                       input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
        logic cl;
        for (int i = 0; i < NI; i++) begin
            port_exp(i, 2*i,   ae,  awe, abe, aad, awd);
            port_exp(i, 2*i+1, bee, bwe, bbe, bad, bwd);
            cl = ae && awe && bee && bwe && (aad == bad);
            if (cl && prio_a_of(i)) begin
                mdl[i][bad] = merge(mdl[i][bad], bwd, bbe);
                mdl[i][aad] = merge(mdl[i][aad], awd, abe);
            end else begin
                if (ae && awe)  mdl[i][aad] = merge(mdl[i][aad], awd, abe);
                if (bee && bwe) mdl[i][bad] = merge(mdl[i][bad], bwd, bbe);
            end
            exp_coll[i] = cl;
            if (cl && cnt_m[i] != 8'hFF) cnt_m[i] = cnt_m[i] + 8'd1;
        end
        if (ae && awe && abe == '1)  known[aad] = 1'b1;
        if (bee && bwe && bbe == '1) known[bad] = 1'b1;
        a_en = ae;  a_we = awe; a_be = abe; a_addr = aad; a_wd = awd;
        b_en = bee; b_we = bwe; b_be = bbe; b_addr = bad; b_wd = bwd;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("d%0d coll", i), 32'(coll_o[i]), 32'(exp_coll[i]));
            check($sformatf("d%0d coll_cnt", i), 32'(cnt_o[i]), 32'(cnt_m[i]));
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cyc(0, 0, '0, '0, '0, 0, 0, '0, '0, '0);
    endtask

    task automatic wr_a(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [NB-1:0] be);
        cyc(1, 1, be, ad, d, 0, 0, '0, '0, '0);
    endtask

    task automatic rd_a(input logic [AW-1:0] ad);
        cyc(1, 0, '0, ad, '0, 0, 0, '0, '0, '0);
    endtask

    task automatic rd_b(input logic [AW-1:0] ad);
        cyc(0, 0, '0, '0, '0, 1, 0, '0, ad, '0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < NP; k++) begin
            if (!rst_n) begin
                check($sformatf("p%0d rvalid in reset", k), 32'(rv[k]), 32'd0);
                check($sformatf("p%0d rdata in reset", k), rd[k], '0);
            end else if (rv[k]) begin
                if (exp_q[k].size() == 0) begin
                    check($sformatf("p%0d spurious rvalid", k), 32'(rv[k]), 32'd0);
                end else begin
                    e = exp_q[k].pop_front();
                    check($sformatf("p%0d latency", k), 32'(cyc_n), e.due);
                    if (!e.dc) check($sformatf("p%0d rdata", k), rd[k], e.d);
                    last_q[k]  = e.d;
                    last_dc[k] = e.dc;
                end
            end else begin
                if (exp_q[k].size() != 0 && exp_q[k][0].due <= 32'(cyc_n)) begin
                    check($sformatf("p%0d missing rvalid", k), 32'(rv[k]), 32'd1);
                    e = exp_q[k].pop_front();
                end
                if (!last_dc[k]) check($sformatf("p%0d rdata hold", k), rd[k], last_q[k]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < NP; k++) begin last_q[k] = '0; last_dc[k] = 1'b0; end
        for (int i = 0; i < NI; i++) begin cnt_m[i] = '0; exp_coll[i] = 1'b0; end
        for (int ad = 0; ad < 16; ad++) known[ad] = 1'b0;
        a_en = 0; a_we = 0; a_be = '0; a_addr = '0; a_wd = '0;
        b_en = 0; b_we = 0; b_be = '0; b_addr = '0; b_wd = '0;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("d%0d coll after reset", i), 32'(coll_o[i]), 32'd0);
            check($sformatf("d%0d coll_cnt after reset", i), 32'(cnt_o[i]), 32'd0);
        end
        rst_n = 1'b1;
        idle(1);

        for (int ad = 0; ad < 16; ad++) wr_a(AW'(ad), $urandom(), '1);

        wr_a(4'd3, 32'h5A, '1);
        rd_b(4'd3);
        idle(2);

        wr_a(4'd2, 32'h1122_3344, 4'hF);
        wr_a(4'd2, 32'hAABB_CCDD, 4'b0101);
        rd_a(4'd2);
        wr_a(4'd2, 32'hFFFF_FFFF, 4'h0);
        rd_b(4'd2);
        idle(2);

        wr_a(4'd5, 32'h10, '1);
        cyc(1, 1, '1, 4'd5, 32'h20, 1, 0, '0, 4'd5, '0);
        rd_a(4'd5);
        cyc(1, 0, '0, 4'd5, '0, 1, 1, '1, 4'd5, 32'h30);
        idle(2);

        cyc(1, 1, '1, 4'd7, 32'hAA, 1, 1, '1, 4'd7, 32'hBB);
        idle(1);
        cyc(1, 0, '0, 4'd7, '0, 1, 0, '0, 4'd7, '0);
        cyc(1, 1, 4'b0011, 4'd8, 32'h1111_2222, 1, 1, 4'b0110, 4'd8, 32'h3333_4444);
        rd_a(4'd8);
        idle(2);

        for (int t = 0; t < 60; t++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NB'($urandom_range(0, 15)),
                AW'($urandom_range(0, 3)), $urandom(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), NB'($urandom_range(0, 15)),
                AW'($urandom_range(0, 3)), $urandom());
        idle(2);

        for (int t = 0; t < 300; t++)
            cyc(1, 1, '1, 4'd9, 32'(t), 1, 1, '1, 4'd9, ~32'(t));
        for (int i = 0; i < NI; i++) check($sformatf("d%0d coll_cnt saturated", i), 32'(cnt_o[i]), 32'd255);
        idle(2);
        for (int i = 0; i < NI; i++) check($sformatf("d%0d coll_cnt holds", i), 32'(cnt_o[i]), 32'd255);

        cyc(1, 0, '0, 4'd0, '0, 1, 0, '0, 4'd2, '0);
        cyc(1, 0, '0, 4'd1, '0, 1, 0, '0, 4'd1, '0);
        cyc(1, 0, '0, 4'd2, '0, 1, 0, '0, 4'd0, '0);
        idle(3);

        cyc(1, 0, '0, 4'd0, '0, 1, 0, '0, 4'd2, '0);
        cyc(1, 0, '0, 4'd1, '0, 1, 0, '0, 4'd1, '0);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NP; k++) begin
            check($sformatf("p%0d rvalid cleared by reset", k), 32'(rv[k]), 32'd0);
            exp_q[k].delete();
            last_q[k]  = '0;
            last_dc[k] = 1'b0;
        end
        for (int i = 0; i < NI; i++) cnt_m[i] = '0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        rd_a(4'd0);
        rd_b(4'd5);
        idle(4);

        for (int k = 0; k < NP; k++) check($sformatf("p%0d queue drained", k), 32'(exp_q[k].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
